// File: rtl/dense_to_loc_extractor_pkg.sv
// Shared constants for the dense-to-location extractor: HQC parameter sets,
// the CLOG2 helper macro and the controller state encoding.
`ifndef CLOG2
`define CLOG2(x) $clog2(x)
`endif

package dense_to_loc_extractor_pkg;

    localparam int HQC128_N      = 17_669;
    localparam int HQC128_M      = 15;
    localparam int HQC128_WEIGHT = 66;

    localparam int HQC192_N      = 35_851;
    localparam int HQC192_M      = 16;
    localparam int HQC192_WEIGHT = 100;

    localparam int HQC256_N      = 57_637;
    localparam int HQC256_M      = 16;
    localparam int HQC256_WEIGHT = 131;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_CAP  = 3'd2;
    localparam logic [2:0] S_SCAN = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

endpackage

// File: rtl/dense_to_loc_extractor_lsb_index_encoder.sv
// Combinational lowest-set-bit encoder: index of the least significant 1 in
// word_i plus a flag telling whether any bit is set at all.
module lsb_index_encoder #(
    parameter int WIDTH = 32,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] word_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             nonzero_o
);

    // NOTE: idx_o is given a default before the loop so no path leaves it
    // unassigned; without it the block would infer a latch.
    always_comb begin
        idx_o = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (word_i[i]) begin
                idx_o = IDX_W'(i);
            end
        end
    end

    assign nonzero_o = |word_i;

endmodule

// File: rtl/dense_to_loc_extractor.sv
// Walks a dense polynomial word by word and emits the bit position of every
// set coefficient, in ascending order, into a location memory.
module dense_to_loc_extractor
    import dense_to_loc_extractor_pkg::*;
#(
    parameter string parameter_set = "hqc128",
    parameter int N          = (parameter_set == "hqc256") ? HQC256_N :
                               (parameter_set == "hqc192") ? HQC192_N : HQC128_N,
    parameter int M          = (parameter_set == "hqc256") ? HQC256_M :
                               (parameter_set == "hqc192") ? HQC192_M : HQC128_M,
    parameter int WEIGHT     = (parameter_set == "hqc256") ? HQC256_WEIGHT :
                               (parameter_set == "hqc192") ? HQC192_WEIGHT : HQC128_WEIGHT,
    parameter int WIDTH      = 32,
    parameter int N_MEM      = ((N + WIDTH - 1) / WIDTH) * WIDTH,
    parameter int DEPTH      = N_MEM / WIDTH,
    parameter int LOG_DEPTH  = `CLOG2(DEPTH),
    parameter int LOG_WEIGHT = `CLOG2(WEIGHT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  pm_rd_en,
    output logic [LOG_DEPTH-1:0]  pm_rd_addr,
    input  logic [WIDTH-1:0]      pm_in,
    output logic                  loc_wr_en,
    output logic [LOG_WEIGHT-1:0] loc_wr_addr,
    output logic [M-1:0]          loc_out,
    output logic [LOG_WEIGHT:0]   count,
    output logic                  overflow,
    output logic                  busy,
    output logic                  done
);

    localparam int LOG_WIDTH  = `CLOG2(WIDTH);
    localparam int VALID_LAST = N - (DEPTH - 1) * WIDTH;
    localparam logic [WIDTH-1:0] LAST_MASK = {WIDTH{1'b1}} >> (WIDTH - VALID_LAST);

    logic [2:0]            state_q, state_d;
    logic [LOG_DEPTH-1:0]  word_addr_q, word_addr_d;
    logic [WIDTH-1:0]      word_reg_q, word_reg_d;
    logic [LOG_WEIGHT:0]   count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  pm_rd_en_q, pm_rd_en_d;
    logic [LOG_DEPTH-1:0]  pm_rd_addr_q, pm_rd_addr_d;
    logic                  loc_wr_en_q, loc_wr_en_d;
    logic [LOG_WEIGHT-1:0] loc_wr_addr_q, loc_wr_addr_d;
    logic [M-1:0]          loc_out_q, loc_out_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic                  last_word;
    logic [WIDTH-1:0]      masked_word;
    logic [WIDTH-1:0]      scan_word;
    logic [LOG_WIDTH-1:0]  lsb_idx;
    logic                  scan_nonzero;
    logic                  advance;

    assign last_word   = (word_addr_q == LOG_DEPTH'(DEPTH - 1));
    assign masked_word = pm_in & (last_word ? LAST_MASK : {WIDTH{1'b1}});

    // Bits still to be emitted for the current word: the freshly captured word
    // in S_CAP, or the scan register with its lowest set bit cleared in S_SCAN.
    assign scan_word = (state_q == S_CAP) ? masked_word
                                          : (word_reg_q & (word_reg_q - WIDTH'(1)));

    lsb_index_encoder #(
        .WIDTH (WIDTH),
        .IDX_W (LOG_WIDTH)
    ) u_lsb (
        .word_i    (scan_word),
        .idx_o     (lsb_idx),
        .nonzero_o (scan_nonzero)
    );

    // Outputs are registered from the next state, so each action appears in
    // the same cycle as the state that owns it.
    always_comb begin
        state_d       = state_q;
        word_addr_d   = word_addr_q;
        word_reg_d    = word_reg_q;
        count_d       = count_q;
        overflow_d    = overflow_q;
        loc_wr_addr_d = loc_wr_addr_q;
        loc_out_d     = loc_out_q;
        loc_wr_en_d   = 1'b0;
        advance       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    word_addr_d   = '0;
                    count_d       = '0;
                    loc_wr_addr_d = '0;
                    overflow_d    = 1'b0;
                    state_d       = S_RD;
                end
            end
            S_RD: state_d = S_CAP;
            S_CAP: begin
                if (scan_nonzero) begin
                    word_reg_d = scan_word;
                    state_d    = S_SCAN;
                end else begin
                    advance = 1'b1;
                end
            end
            S_SCAN: begin
                word_reg_d = scan_word;
                advance    = !scan_nonzero;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (advance) begin
            if (last_word) begin
                state_d = S_DONE;
            end else begin
                word_addr_d = word_addr_q + LOG_DEPTH'(1);
                state_d     = S_RD;
            end
        end

        // Beyond WEIGHT the scan continues but only records the overflow.
        if (state_d == S_SCAN) begin
            if (count_q < (LOG_WEIGHT + 1)'(WEIGHT)) begin
                loc_wr_en_d   = 1'b1;
                loc_wr_addr_d = LOG_WEIGHT'(count_q);
                loc_out_d     = M'({word_addr_q, lsb_idx});
                count_d       = count_q + (LOG_WEIGHT + 1)'(1);
            end else begin
                overflow_d = 1'b1;
            end
        end

        pm_rd_en_d   = (state_d == S_RD);
        pm_rd_addr_d = word_addr_d;
        busy_d       = (state_d != S_IDLE);
        done_d       = (state_d == S_DONE);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            word_addr_q   <= '0;
            word_reg_q    <= '0;
            count_q       <= '0;
            overflow_q    <= 1'b0;
            pm_rd_en_q    <= 1'b0;
            pm_rd_addr_q  <= '0;
            loc_wr_en_q   <= 1'b0;
            loc_wr_addr_q <= '0;
            loc_out_q     <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            word_addr_q   <= word_addr_d;
            word_reg_q    <= word_reg_d;
            count_q       <= count_d;
            overflow_q    <= overflow_d;
            pm_rd_en_q    <= pm_rd_en_d;
            pm_rd_addr_q  <= pm_rd_addr_d;
            loc_wr_en_q   <= loc_wr_en_d;
            loc_wr_addr_q <= loc_wr_addr_d;
            loc_out_q     <= loc_out_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign pm_rd_en    = pm_rd_en_q;
    assign pm_rd_addr  = pm_rd_addr_q;
    assign loc_wr_en   = loc_wr_en_q;
    assign loc_wr_addr = loc_wr_addr_q;
    assign loc_out     = loc_out_q;
    assign count       = count_q;
    assign overflow    = overflow_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_dense_to_loc_extractor.sv
// Self-checking bench for dense_to_loc_extractor (hqc128, WIDTH 32): table of
// directed vectors, hand-written overflow/reset sequences and random vectors.
module tb_dense_to_loc_extractor;

    localparam int N          = 17_669;
    localparam int WIDTH      = 32;
    localparam int DEPTH      = 553;
    localparam int N_MEM      = DEPTH * WIDTH;
    localparam int WEIGHT     = 66;
    localparam int LOG_DEPTH  = 10;
    localparam int LOG_WEIGHT = 7;
    localparam int M          = 15;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start;
    logic                  pm_rd_en;
    logic [LOG_DEPTH-1:0]  pm_rd_addr;
    logic [WIDTH-1:0]      pm_in = '0;
    logic                  loc_wr_en;
    logic [LOG_WEIGHT-1:0] loc_wr_addr;
    logic [M-1:0]          loc_out;
    logic [LOG_WEIGHT:0]   count;
    logic                  overflow;
    logic                  busy;
    logic                  done;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] mem [DEPTH];
    int model_q [$];

    dense_to_loc_extractor dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .pm_rd_en    (pm_rd_en),
        .pm_rd_addr  (pm_rd_addr),
        .pm_in       (pm_in),
        .loc_wr_en   (loc_wr_en),
        .loc_wr_addr (loc_wr_addr),
        .loc_out     (loc_out),
        .count       (count),
        .overflow    (overflow),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Dense memory with one-cycle read latency.
    always @(posedge clk) begin
        if (pm_rd_en) pm_in <= mem[pm_rd_addr];
    end

    task automatic check(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    endtask

    task automatic set_bit(input int p);
        mem[p / WIDTH][p % WIDTH] = 1'b1;
    endtask

    // Reference: every set bit below N, in ascending position order.
    task automatic build_model();
        model_q.delete();
        for (int p = 0; p < N; p++) begin
            if (mem[p / WIDTH][p % WIDTH]) model_q.push_back(p);
        end
    endtask

    task automatic check_outputs_zero(input string name);
        check(name, {pm_rd_en, pm_rd_addr, loc_wr_en, loc_wr_addr, loc_out,
                     count, overflow, busy, done}, 0);
    endtask

    // Starts a scan, collects writes, and compares against the model plus the
    // given expectations (exp_run < 0 skips the back-to-back run check).
    task automatic run_scan(input string name, input int exp_count, input int exp_done,
                            input bit exp_ovf, input int exp_run);
        int got_addr [$];
        int got_val [$];
        int cyc, done_cyc, run, max_run;
        build_model();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        done_cyc = -1;
        run = 0;
        max_run = 0;
        check({name, ".busy_on"}, busy, 1);
        for (int t = 0; t < 3000; t++) begin
            if (loc_wr_en) begin
                got_addr.push_back(int'(loc_wr_addr));
                got_val.push_back(int'(loc_out));
                run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
            if (done) begin
                done_cyc = cyc;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        check({name, ".done_cycle"}, done_cyc, exp_done);
        check({name, ".count"}, count, exp_count);
        check({name, ".overflow"}, overflow, exp_ovf);
        check({name, ".n_writes"}, got_addr.size(), exp_count);
        check({name, ".model_count"}, got_addr.size(),
              (model_q.size() > WEIGHT) ? WEIGHT : model_q.size());
        if (exp_run >= 0) check({name, ".max_run"}, max_run, exp_run);
        for (int j = 0; j < got_addr.size(); j++) begin
            check($sformatf("%s.slot%0d_addr", name, j), got_addr[j], j);
            check($sformatf("%s.slot%0d_loc", name, j), got_val[j],
                  (j < model_q.size()) ? model_q[j] : -1);
        end
        @(negedge clk);
        check({name, ".done_pulse"}, done, 0);
        check({name, ".busy_off"}, busy, 0);
        check({name, ".count_hold"}, count, exp_count);
    endtask

    typedef struct {
        string       name;
        int          npos;
        int          pos [4];
        int          raw_addr;
        logic [31:0] raw_val;
        int          exp_count;
        int          exp_done;
        bit          exp_ovf;
        int          exp_run;
    } vec_t;

    vec_t vecs [4];

    initial begin
        int nw, nb, ovf_cnt;
        int rpos [10];

        vecs[0] = '{"all_zero",   0, '{0, 0, 0, 0},         -1,  32'h0,          0, 1107, 1'b0, 0};
        vecs[1] = '{"four_bits",  4, '{0, 31, 32, 17668},   -1,  32'h0,          4, 1111, 1'b0, 2};
        vecs[2] = '{"padding",    0, '{0, 0, 0, 0},         552, 32'hFFFF_FFE0,  0, 1107, 1'b0, 0};
        vecs[3] = '{"full_word0", 0, '{0, 0, 0, 0},         0,   32'hFFFF_FFFF, 32, 1139, 1'b0, 32};

        rst = 1'b1;
        start = 1'b0;
        clear_mem();
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset_outputs");
        @(negedge clk);
        rst = 1'b0;

        for (int v = 0; v < 4; v++) begin
            clear_mem();
            for (int k = 0; k < vecs[v].npos; k++) set_bit(vecs[v].pos[k]);
            if (vecs[v].raw_addr >= 0) mem[vecs[v].raw_addr] = vecs[v].raw_val;
            run_scan(vecs[v].name, vecs[v].exp_count, vecs[v].exp_done,
                     vecs[v].exp_ovf, vecs[v].exp_run);
        end

        // 67 valid set bits, each in its own word.
        clear_mem();
        for (int i = 0; i < 67; i++) set_bit(i * 263);
        run_scan("overflow", 66, 1 + 2 * DEPTH + 67, 1'b1, 1);

        // Reset during the third write of a 10-bit vector, then rerun.
        rpos = '{5, 6, 7, 100, 101, 5000, 9000, 12000, 17000, 17668};
        clear_mem();
        for (int i = 0; i < 10; i++) set_bit(rpos[i]);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nw = 0;
        for (int t = 0; t < 100 && nw < 3; t++) begin
            if (loc_wr_en) nw++;
            if (nw < 3) @(negedge clk);
        end
        check("midreset.reached_third_write", nw, 3);
        rst = 1'b1;
        #1;
        check_outputs_zero("midreset.outputs");
        @(negedge clk);
        check_outputs_zero("midreset.held");
        rst = 1'b0;
        run_scan("after_reset", 10, 1 + 2 * DEPTH + 10, 1'b0, 3);

        // Random vectors, padding bits included; the model ignores them.
        for (int r = 0; r < 6; r++) begin
            clear_mem();
            nb = $urandom_range(0, 80);
            for (int k = 0; k < nb; k++) set_bit($urandom_range(0, N_MEM - 1));
            build_model();
            ovf_cnt = model_q.size();
            run_scan($sformatf("rand%0d", r), (ovf_cnt > WEIGHT) ? WEIGHT : ovf_cnt,
                     1 + 2 * DEPTH + ovf_cnt, ovf_cnt > WEIGHT, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
